ir_fetch_stage: RTL and testbench

- Upstream feeder of the microcode sequencer: buffers instruction words arriving from the memory bus in a small FIFO.
- Presents the head instruction's opcode, plus registered carry/zero flags, as the sequencer's dispatch inputs.
- Pops an instruction on the sequencer's consume strobe and discards buffered words on a flush (taken jump).
- Also owns the architectural carry/zero flag register loaded from the ALU.

---
 rtl/ir_fetch_stage_pkg.sv | 21 ++
 rtl/ir_fetch_stage_sync_fifo.sv | 85 ++++++++
 rtl/ir_fetch_stage.sv | 100 ++++++++++
 tb/tb_ir_fetch_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_fetch_stage_pkg.sv
// ir_fetch_stage_pkg
//   Shared constants for the instruction fetch stage: default word and
//   opcode widths, the buffer depth, the opcode presented while the buffer
//   is empty, and a helper that locates the opcode field inside a word.
package ir_fetch_stage_pkg;

  localparam int WORD_W_DEF   = 16;
  localparam int OPCODE_W_DEF = 7;
  localparam int DEPTH_DEF    = 2;

  // Opcode 0 is the sequencer's fetch-wait dispatch entry: the microcode
  // spins there until a real instruction shows up.
  localparam logic [OPCODE_W_DEF-1:0] OPCODE_EMPTY = '0;

  // The opcode occupies the top opcode_w bits of the word; this returns the
  // bit index of its LSB (which is also the width of the operand field).
  function automatic int opcode_lsb(input int word_w, input int opcode_w);
    return word_w - opcode_w;
  endfunction

endpackage

// File: rtl/ir_fetch_stage_sync_fifo.sv
// ir_fetch_stage_sync_fifo
//   Small synchronous FIFO with push, pop and flush. Requests are qualified
//   internally: a push is ignored when full, a pop when empty, and a flush
//   discards everything including any same-cycle push or pop.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   push_i, wdata_i write request and data
//   pop_i           remove head entry
//   flush_i         empty the buffer and rewind both pointers
//   rdata_o         storage at the read pointer (not gated)
//   count_o         number of valid entries
//   full_o          count_o == DEPTH
module ir_fetch_stage_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign push_en = push_i && !full_o && !flush_i;
  assign pop_en  = pop_i && !empty && !flush_i;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ir_fetch_stage.sv
// ir_fetch_stage
//   Upstream feeder of the microcode sequencer. Buffers instruction words
//   from the memory bus, presents the head opcode/operand and the
//   architectural carry/zero flags as dispatch inputs, pops on consume,
//   discards on flush, and flags a consume attempted while empty.
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   mem_data/valid/ready     memory bus word handshake; a word transfers on
//                            a cycle with mem_valid && mem_ready and no flush.
//                            mem_ready depends only on registered state.
//   ir_consume               pop head instruction
//   ir_flush                 discard all buffered words (flags untouched)
//   flag_load, alu_carry/zero  capture ALU flags
//   opcode, operand, ir_valid  head instruction fields, zero when empty
//   carry, zero              registered flags
//   underrun                 sticky: consume seen while empty
module ir_fetch_stage
  import ir_fetch_stage_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WORD_W-1:0]          mem_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic                       ir_consume,
  input  logic                       ir_flush,
  input  logic                       flag_load,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [WORD_W-OPCODE_W-1:0] operand,
  output logic                       ir_valid,
  output logic                       carry,
  output logic                       zero,
  output logic                       underrun
);

  localparam int OPC_LSB = opcode_lsb(WORD_W, OPCODE_W);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              underrun_q, underrun_d;

  ir_fetch_stage_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (mem_valid),
    .wdata_i (mem_data),
    .pop_i   (ir_consume),
    .flush_i (ir_flush),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full)
  );

  assign mem_ready = !full;
  assign ir_valid  = (count != '0);
  assign opcode    = ir_valid ? head[WORD_W-1:OPC_LSB] : OPCODE_W'(OPCODE_EMPTY);
  assign operand   = ir_valid ? head[OPC_LSB-1:0] : '0;

  always_comb begin
    carry_d    = carry_q;
    zero_d     = zero_q;
    underrun_d = underrun_q;
    if (flag_load) begin
      carry_d = alu_carry;
      zero_d  = alu_zero;
    end
    // A flush takes priority over the consume, so it cannot underrun.
    if (ir_consume && !ir_valid && !ir_flush) underrun_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      underrun_q <= underrun_d;
    end
  end

  assign carry    = carry_q;
  assign zero     = zero_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ir_fetch_stage.sv
module tb_ir_fetch_stage;

  localparam int DEPTH = 2;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        ir_consume;
  logic        ir_flush;
  logic        flag_load;
  logic        alu_carry;
  logic        alu_zero;
  logic [6:0]  opcode;
  logic [8:0]  operand;
  logic        ir_valid;
  logic        carry;
  logic        zero;
  logic        underrun;

  ir_fetch_stage dut (
    .clock      (clock),
    .reset      (reset),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .ir_consume (ir_consume),
    .ir_flush   (ir_flush),
    .flag_load  (flag_load),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .opcode     (opcode),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .carry      (carry),
    .zero       (zero),
    .underrun   (underrun)
  );

  // reference model: buffer contents as a queue plus flag/sticky bits
  logic [15:0] exp_q[$];
  logic        m_carry, m_zero, m_underrun;
  int          total = 0;
  int          bad = 0;

  always @(posedge clock) begin
    bit do_push, do_pop;
    if (reset) begin
      exp_q.delete();
      m_carry    = 1'b0;
      m_zero     = 1'b0;
      m_underrun = 1'b0;
    end else begin
      if (ir_flush) begin
        exp_q.delete();
      end else begin
        do_push = mem_valid && (exp_q.size() < DEPTH);
        do_pop  = ir_consume && (exp_q.size() > 0);
        if (ir_consume && exp_q.size() == 0) m_underrun = 1'b1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(mem_data);
      end
      if (flag_load) begin
        m_carry = alu_carry;
        m_zero  = alu_zero;
      end
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [15:0] head;
    bit          nonempty;
    nonempty = (exp_q.size() > 0);
    head     = nonempty ? exp_q[0] : 16'h0000;
    chk("m_mem_ready", {31'd0, mem_ready}, {31'd0, exp_q.size() < DEPTH});
    chk("m_ir_valid",  {31'd0, ir_valid},  {31'd0, nonempty});
    chk("m_opcode",    {25'd0, opcode},    {25'd0, head[15:9]});
    chk("m_operand",   {23'd0, operand},   {23'd0, head[8:0]});
    chk("m_carry",     {31'd0, carry},     {31'd0, m_carry});
    chk("m_zero",      {31'd0, zero},      {31'd0, m_zero});
    chk("m_underrun",  {31'd0, underrun},  {31'd0, m_underrun});
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic c, input logic f, input logic fl,
                       input logic ac, input logic az);
    reset      = r;
    mem_valid  = v;
    mem_data   = d;
    ir_consume = c;
    ir_flush   = f;
    flag_load  = fl;
    alu_carry  = ac;
    alu_zero   = az;
  endtask

  // one clock: inputs applied across the posedge, outputs checked at negedge
  task automatic step();
    @(negedge clock);
    check_model();
  endtask

  logic [15:0] words [11];

  initial begin
    drive(1, 0, 16'h0, 0, 0, 0, 0, 0);
    @(negedge clock);
    step();
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_ir_valid",  {31'd0, ir_valid},  32'd0);
    chk("rst_opcode",    {25'd0, opcode},    32'd0);
    chk("rst_operand",   {23'd0, operand},   32'd0);
    chk("rst_flags",     {30'd0, carry, zero}, 32'd0);
    chk("rst_underrun",  {31'd0, underrun},  32'd0);

    // single push
    drive(0, 1, 16'hA5C3, 0, 0, 0, 0, 0); step();
    chk("push_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("push_opcode",   {25'd0, opcode},   32'h52);
    chk("push_operand",  {23'd0, operand},  32'h1C3);
    chk("push_ready",    {31'd0, mem_ready}, 32'd1);
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();
    chk("pop_empty", {31'd0, ir_valid}, 32'd0);

    // fill to full, third word refused
    drive(0, 1, 16'h1111, 0, 0, 0, 0, 0); step();
    drive(0, 1, 16'h2222, 0, 0, 0, 0, 0); step();
    chk("full_ready",  {31'd0, mem_ready}, 32'd0);
    chk("full_opcode", {25'd0, opcode},    32'h08);
    drive(0, 1, 16'h3333, 0, 0, 0, 0, 0); step();
    chk("full_hold_opcode", {25'd0, opcode}, 32'h08);
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();
    chk("after_pop_opcode", {25'd0, opcode},    32'h11);
    chk("after_pop_ready",  {31'd0, mem_ready}, 32'd1);
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();
    chk("drained", {31'd0, ir_valid}, 32'd0);

    // steady stream through pointer wrap
    for (int i = 0; i < 11; i++) words[i] = 16'($urandom);
    drive(0, 1, words[0], 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, words[i+1], 1, 0, 0, 0, 0); step();
      chk("stream_valid",  {31'd0, ir_valid}, 32'd1);
      chk("stream_opcode", {25'd0, opcode}, {25'd0, words[i+1][15:9]});
    end
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();

    // flush with push and consume in the same cycle
    drive(0, 1, 16'h4444, 0, 0, 0, 0, 0); step();
    drive(0, 1, 16'h5555, 0, 0, 0, 0, 0); step();
    drive(0, 1, 16'h6666, 1, 1, 0, 0, 0); step();
    chk("flush_valid",    {31'd0, ir_valid}, 32'd0);
    chk("flush_opcode",   {25'd0, opcode},   32'd0);
    chk("flush_underrun", {31'd0, underrun}, 32'd0);
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0); step();
    chk("flush_dropped", {31'd0, ir_valid}, 32'd0);

    // underrun sticky until reset
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();
    chk("underrun_set", {31'd0, underrun}, 32'd1);
    drive(0, 1, 16'h7777, 0, 0, 0, 0, 0); step();
    chk("underrun_hold", {31'd0, underrun}, 32'd1);
    drive(0, 0, 16'h0, 1, 0, 0, 0, 0); step();
    drive(1, 0, 16'h0, 0, 0, 0, 0, 0); step();
    chk("underrun_clr", {31'd0, underrun}, 32'd0);

    // flags load, hold, survive flush, cleared by reset
    drive(0, 0, 16'h0, 0, 0, 1, 1, 0); step();
    chk("flag_load", {30'd0, carry, zero}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'(8000 + i), 0, 0, 0, i[0], ~i[0]); step();
      chk("flag_hold", {30'd0, carry, zero}, 32'd2);
    end
    drive(0, 0, 16'h0, 0, 1, 0, 0, 1); step();
    chk("flag_flush", {30'd0, carry, zero}, 32'd2);
    drive(0, 1, 16'h9999, 0, 0, 0, 0, 0); step();
    drive(1, 1, 16'hAAAA, 1, 0, 1, 1, 1); step();
    chk("midrst_flags", {30'd0, carry, zero}, 32'd0);
    chk("midrst_valid", {31'd0, ir_valid},    32'd0);
    chk("midrst_ready", {31'd0, mem_ready},   32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0,
            16'($urandom),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0,
            1'($urandom), 1'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
